// File: rtl/spi_mem_pkg.sv
// Shared constants and FSM state type for the SPI flash/PSRAM controller.
package spi_mem_pkg;
   localparam logic [7:0] CMD_READ    = 8'h03;
   localparam logic [7:0] CMD_WRITE   = 8'h02;
   localparam int         ADDR_BITS   = 24;
   localparam logic [5:0] NBITS_SHORT = 6'd40;
   localparam logic [5:0] NBITS_LONG  = 6'd48;
   localparam logic [5:0] DATA_START  = 6'd32;

   typedef enum logic [1:0] {ST_IDLE, ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD} state_t;
endpackage

// File: rtl/spi_mem_if.sv
// Request/response bus between a requester and spi_mem_ctrl.
interface spi_mem_if;
   import spi_mem_pkg::*;
   logic                 req_valid_in;
   logic                 req_ready_out;
   logic                 req_sel_in;
   logic                 req_we_in;
   logic                 req_len2_in;
   logic [ADDR_BITS-1:0] req_addr_in;
   logic [7:0]           req_wdata_in;
   logic                 rsp_valid_out;
   logic [15:0]          rsp_rdata_out;

   modport master (output req_valid_in, req_sel_in, req_we_in, req_len2_in, req_addr_in,
                   req_wdata_in, input req_ready_out, rsp_valid_out, rsp_rdata_out);
   modport slave  (input req_valid_in, req_sel_in, req_we_in, req_len2_in, req_addr_in,
                   req_wdata_in, output req_ready_out, rsp_valid_out, rsp_rdata_out);
endinterface

// File: rtl/spi_mem_sclk_gen.sv
// SCLK divider: DIV_HALF clocks per half period, one-cycle rise/fall/done strobes.
module spi_mem_sclk_gen #(
   parameter int DIV_HALF = 2
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic i_en,
   input  logic i_last,
   output logic o_rise,
   output logic o_fall,
   output logic o_done,
   output logic o_sclk
);
   localparam logic [7:0] DH_M1 = 8'(DIV_HALF - 1);

   logic [7:0] r_div;
   logic       r_sclk;
   logic       w_tick;

   assign w_tick = i_en && (r_div == 8'd0);
   // After the low half of the final bit, the rise is replaced by done.
   assign o_rise = w_tick && !r_sclk && !i_last;
   assign o_done = w_tick && !r_sclk && i_last;
   assign o_fall = w_tick && r_sclk;
   assign o_sclk = r_sclk;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_div  <= 8'd0;
         r_sclk <= 1'b0;
      end else if (!i_en) begin
         r_div  <= 8'd0;
         r_sclk <= 1'b0;
      end else if (w_tick) begin
         r_div <= DH_M1;
         if (o_rise)      r_sclk <= 1'b1;
         else if (o_fall) r_sclk <= 1'b0;
      end else begin
         r_div <= r_div - 8'd1;
      end
   end
endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 controller for a flash and a PSRAM sharing SCLK/MOSI/MISO.
// Writes (cmd 02) exist only when SPI_MEM_WRITE_EN is defined.
module spi_mem_ctrl
   import spi_mem_pkg::*;
#(
   parameter int DIV_HALF = 2
) (
   input  logic      clk_in,
   input  logic      rst_n_in,
   spi_mem_if.slave  bus,
   output logic      sclk_out,
   output logic      flash_cs_n_out,
   output logic      psram_cs_n_out,
   output logic      mosi_out,
   input  logic      miso_in
);
   localparam logic [7:0] DH_M1 = 8'(DIV_HALF - 1);

   state_t      r_state, w_next;
   logic [5:0]  r_bitcnt, r_nbits;
   logic [47:0] r_tx;
   logic [15:0] r_rx, r_rdata;
   logic [7:0]  r_wcnt;
   logic [1:0]  r_cs_n;
   logic        r_we, r_rsp_valid;
   logic        w_accept, w_rise, w_fall, w_done, w_we;
   logic [7:0]  w_data_byte;

`ifdef SPI_MEM_WRITE_EN
   assign w_we        = bus.req_we_in;
   assign w_data_byte = bus.req_we_in ? bus.req_wdata_in : 8'h00;
`else
   logic w_unused;
   assign w_unused    = &{1'b0, bus.req_we_in, bus.req_wdata_in};
   assign w_we        = 1'b0;
   assign w_data_byte = 8'h00;
`endif

   assign w_accept          = bus.req_valid_in && (r_state == ST_IDLE);
   assign bus.req_ready_out = (r_state == ST_IDLE);
   assign bus.rsp_valid_out = r_rsp_valid;
   assign bus.rsp_rdata_out = r_rdata;
   assign mosi_out          = r_tx[47];
   assign flash_cs_n_out    = r_cs_n[0];
   assign psram_cs_n_out    = r_cs_n[1];

   spi_mem_sclk_gen #(.DIV_HALF(DIV_HALF)) u_sclk (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .i_en     (r_state == ST_SHIFT),
      .i_last   (r_bitcnt == r_nbits),
      .o_rise   (w_rise),
      .o_fall   (w_fall),
      .o_done   (w_done),
      .o_sclk   (sclk_out)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_state <= ST_IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:     if (bus.req_valid_in) w_next = ST_CS_SETUP;
         ST_CS_SETUP: if (r_wcnt == 8'd0)   w_next = ST_SHIFT;
         ST_SHIFT:    if (w_done)           w_next = ST_CS_HOLD;
         ST_CS_HOLD:  if (r_wcnt == 8'd0)   w_next = ST_IDLE;
         default:                           w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_tx        <= '0;
         r_rx        <= '0;
         r_rdata     <= '0;
         r_bitcnt    <= '0;
         r_nbits     <= '0;
         r_wcnt      <= '0;
         r_cs_n      <= 2'b11;
         r_we        <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (w_accept) begin
            // Whole frame preloaded MSB first; zeros shift in behind it.
            r_tx     <= {(w_we ? CMD_WRITE : CMD_READ), bus.req_addr_in, w_data_byte, 8'h00};
            r_rx     <= '0;
            r_bitcnt <= '0;
            r_we     <= w_we;
            r_nbits  <= (!w_we && bus.req_len2_in) ? NBITS_LONG : NBITS_SHORT;
            r_cs_n   <= bus.req_sel_in ? 2'b01 : 2'b10;
            r_wcnt   <= DH_M1;
         end else if (r_wcnt != 8'd0) begin
            r_wcnt <= r_wcnt - 8'd1;
         end
         if (w_rise) begin
            r_bitcnt <= r_bitcnt + 6'd1;
            if (!r_we && r_bitcnt >= DATA_START) r_rx <= {r_rx[14:0], miso_in};
         end
         if (w_fall) r_tx <= {r_tx[46:0], 1'b0};
         if (w_done) begin
            r_cs_n      <= 2'b11;
            r_rsp_valid <= 1'b1;
            r_rdata     <= r_rx;
            r_tx        <= '0;
            r_wcnt      <= DH_M1;
         end
      end
   end
endmodule

// File: doc/spi_mem_ctrl.md
SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_HALF, default 2, meaning system clocks per SCLK half-period (legal range 1..255).
REQ-002 The block SHALL have clk_in, input, 1, single system clock (all logic on rising edge).
REQ-003 The block SHALL have rst_n_in, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have req_valid_in / req_ready_out, in/out, 1 each, request handshake; a request is accepted on a clock edge where both are high.
REQ-005 The block SHALL have req_sel_in (1; 0=flash, 1=psram), req_we_in (1), req_len2_in (1; two-byte read), req_addr_in (24) and req_wdata_in (8) as inputs, sampled only on acceptance.
REQ-006 The block SHALL have rsp_valid_out, output, 1, a one-cycle completion pulse, and rsp_rdata_out, output, 16, read data that is held until the next acceptance.
REQ-007 The block SHALL have sclk_out, flash_cs_n_out, psram_cs_n_out and mosi_out as 1-bit outputs, and miso_in as a 1-bit input.

Function
REQ-008 The block SHALL run FSM states IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> IDLE; req_ready_out is high only in IDLE.
REQ-009 The frame SHALL be: command (8'h03 read, 8'h02 write), then 24-bit address, then data, all MSB first.
REQ-010 Frame bit count nbits SHALL be 40 for a write or a single-byte read, and 48 when req_len2_in=1 on a read.
REQ-011 req_len2_in SHALL be ignored on writes.
REQ-012 Only the CS selected by req_sel_in SHALL be low, from CS_SETUP through the end of SHIFT; both CS stay high otherwise.
REQ-013 SCLK SHALL idle low (mode 0).
REQ-014 CS_SETUP SHALL last DIV_HALF clocks, with mosi_out driven to the command MSB.
REQ-015 In SHIFT, each bit SHALL be DIV_HALF clocks with sclk_out high, then DIV_HALF clocks low.
REQ-016 miso_in SHALL be sampled on the clock where sclk_out rises.
REQ-017 mosi_out SHALL advance to the next bit on the clock where sclk_out falls.
REQ-018 mosi_out SHALL be 0 during the data phase of reads and outside frames.
REQ-019 A 6-bit bit counter SHALL count rising SCLK edges (0..nbits) and end SHIFT after the low half of bit nbits.
REQ-020 Read data SHALL come only from bits 33..nbits.
REQ-021 A single-byte read SHALL return {8'h00, byte}.
REQ-022 A two-byte read SHALL return {first byte, second byte}.
REQ-023 A write SHALL return 16'h0000.
REQ-024 rsp_valid_out SHALL pulse on the first CS_HOLD clock.
REQ-025 rsp_valid_out SHALL occur exactly DIV_HALF*(2*nbits+1)+1 clocks after the acceptance edge.
REQ-026 CS_HOLD SHALL last DIV_HALF clocks, with both CS high, before req_ready_out returns.
REQ-027 Back-to-back requests SHALL therefore be separated by at least DIV_HALF clocks of CS high.
REQ-028 req_valid_in held high in IDLE SHALL be accepted in the first IDLE cycle.
REQ-029 Requests SHALL be executed as issued, with no protection checks; a write to flash is sent as-is.

Reset
REQ-030 Reset SHALL be asynchronous, taking effect immediately and mid-frame included.
REQ-031 Reset values SHALL be: state=IDLE, req_ready_out=1 after reset release, rsp_valid_out=0, rsp_rdata_out=16'h0000, sclk_out=0, flash_cs_n_out=1, psram_cs_n_out=1, mosi_out=0, bit counter and divider counter=0.
REQ-032 An interrupted frame SHALL produce no rsp_valid_out.

Configuration
REQ-033 The write feature SHALL be gated by macro SPI_MEM_WRITE_EN.
REQ-034 With SPI_MEM_WRITE_EN defined, req_we_in=1 SHALL issue 8'h02 followed by req_wdata_in.
REQ-035 Without SPI_MEM_WRITE_EN, req_we_in SHALL be ignored (treated as 0), all requests SHALL be reads, and the wdata path SHALL be absent.

Structure
REQ-036 Package spi_mem_pkg SHALL hold CMD_READ=8'h03, CMD_WRITE=8'h02, ADDR_BITS=24, the FSM state enum, and the frame-length constants 40 and 48.
REQ-037 Sub-module spi_mem_sclk_gen SHALL hold the divider counter and issue one-cycle rise/fall strobes plus sclk_out; the FSM and shift registers stay in spi_mem_ctrl.

Verification (DIV_HALF=2, attached flash and psram memory models)
REQ-038 Reset values: assert rst_n_in=0 -> both CS high, sclk_out=0, req_ready_out=1 after release, rsp_valid_out=0.
REQ-039 Single-byte flash read: flash[0x000010]=8'hA5, read sel=0 addr=0x000010 len2=0 -> mosi bits 0x03,0x000010; rsp_valid_out at +163 clocks; rdata=16'h00A5.
REQ-040 Two-byte flash read: flash[0x10]=8'hA5, flash[0x11]=8'h3C, read len2=1 -> rsp_valid_out at +195 clocks; rdata=16'hA53C; exactly 48 SCLK rising edges.
REQ-041 PSRAM write then read (SPI_MEM_WRITE_EN): write sel=1 addr=0x000123 wdata=8'h5A, then read the same address -> write rdata=0; read rdata=16'h005A; a gap of at least 2 clocks of CS high between frames.
REQ-042 Reset mid-frame: assert rst_n_in at bit 20 -> psram_cs_n_out=1 the same cycle; no rsp_valid_out; the next read succeeds.
REQ-043 Continuous requests: req_valid_in held high for 3 reads -> 3 accepts, 3 rsp pulses, never both CS low at once.
